// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - serial line and byte-side signals of the UART receiver
//
// Ports (as signals of the bundle):
//   rx         serial line into the receiver, idle high
//   data       last correctly framed byte
//   received   one-cycle strobe, data updated this cycle
//   receiving  high while a frame is in progress
//   frame_err  one-cycle strobe, stop bit sampled low
//
// slave modport is taken by the receiver; master is the line driver / byte consumer.
interface uart_receiver_if;
  logic       rx;
  logic [7:0] data;
  logic       received;
  logic       receiving;
  logic       frame_err;

  modport slave (
    input  rx,
    output data,
    output received,
    output receiving,
    output frame_err
  );

  modport master (
    output rx,
    input  data,
    input  received,
    input  receiving,
    input  frame_err
  );
endinterface

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with 16x oversampling
//
// Parameters:
//   OVS_DIV    clk cycles per oversample tick (2..65535); 16 ticks per bit
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   rx_if      slave side of uart_receiver_if (rx in; data/received/receiving/frame_err out)
module uart_receiver #(
  parameter int OVS_DIV = 326
) (
  input  logic            clk,
  input  logic            rst,
  uart_receiver_if.slave  rx_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  localparam logic [15:0] DIV_LAST = 16'(OVS_DIV - 1);

  state_e      state_q, state_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic        s2_prev_q, s2_prev_d;
  logic [15:0] div_q, div_d;
  logic [3:0]  tcnt_q, tcnt_d;
  logic [2:0]  bidx_q, bidx_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  data_q, data_d;
  logic        received_q, received_d;
  logic        receiving_q, receiving_d;
  logic        frame_err_q, frame_err_d;

  logic tick;
  logic fall;

  assign tick = (div_q == DIV_LAST);
  // s2_prev_q lags s2_q by one cycle, so this sees the synchronized line going 1 -> 0.
  assign fall = s2_prev_q & ~s2_q;

  always_comb begin
    state_d     = state_q;
    s1_d        = rx_if.rx;
    s2_d        = s1_q;
    s2_prev_d   = s2_q;
    div_d       = div_q;
    tcnt_d      = tcnt_q;
    bidx_d      = bidx_q;
    sh_d        = sh_q;
    data_d      = data_q;
    received_d  = 1'b0;
    frame_err_d = 1'b0;

    // Free-running divider while a frame is active; the IDLE/WAIT_IDLE
    // branches below pin it to 0 so START always begins at div==0.
    if (tick) begin
      div_d = 16'd0;
    end else begin
      div_d = div_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        div_d = 16'd0;
        if (fall) begin
          state_d = S_START;
          tcnt_d  = 4'd0;
        end
      end

      S_START: begin
        if (tick) begin
          if (tcnt_q == 4'd7) begin
            // Mid start bit: a line that is already high again was a glitch.
            if (!s2_q) begin
              state_d = S_DATA;
              tcnt_d  = 4'd0;
              bidx_d  = 3'd0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          if (tcnt_q == 4'd15) begin
            sh_d   = {s2_q, sh_q[7:1]};
            tcnt_d = 4'd0;
            if (bidx_q == 3'd7) begin
              state_d = S_STOP;
            end else begin
              bidx_d = bidx_q + 3'd1;
            end
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end

      S_STOP: begin
        if (tick) begin
          if (tcnt_q == 4'd15) begin
            tcnt_d = 4'd0;
            if (s2_q) begin
              data_d     = sh_q;
              received_d = 1'b1;
              state_d    = S_IDLE;
            end else begin
              // Stop bit low: report it and wait out any break before rearming.
              frame_err_d = 1'b1;
              state_d     = S_WAIT_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end

      S_WAIT_IDLE: begin
        div_d = 16'd0;
        if (s2_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        div_d   = 16'd0;
      end
    endcase

    // Registered from the next state so it drops on the same edge the strobe rises.
    receiving_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      s2_prev_q   <= 1'b1;
      div_q       <= 16'd0;
      tcnt_q      <= 4'd0;
      bidx_q      <= 3'd0;
      sh_q        <= 8'h00;
      data_q      <= 8'h00;
      received_q  <= 1'b0;
      receiving_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s2_prev_q   <= s2_prev_d;
      div_q       <= div_d;
      tcnt_q      <= tcnt_d;
      bidx_q      <= bidx_d;
      sh_q        <= sh_d;
      data_q      <= data_d;
      received_q  <= received_d;
      receiving_q <= receiving_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_if.data      = data_q;
  assign rx_if.received  = received_q;
  assign rx_if.receiving = receiving_q;
  assign rx_if.frame_err = frame_err_q;

endmodule
